// File: rtl/hht_pkg.sv
// Shared types and constants for the HHT memory server.
package hht_pkg;

   // Every address and data word in the server is 32 bits wide.
   typedef logic [31:0] word_t;

   // Server phases: IDLE after reset, LOAD while filling, SERVE while reading.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SERVE = 2'd2
   } state_t;

   // Returned for unmapped, unwritten or load-phase reads.
   localparam word_t DEFAULT_DATA = 32'd99999;

endpackage

// File: rtl/hht_rd_port.sv
// One read port: window compare against its region, and the registered
// data/valid/oob outputs with a fixed one-cycle latency.
module hht_rd_port
   import hht_pkg::*;
#(
   parameter int unsigned DEPTH        = 256,
   parameter word_t       DEFAULT_DATA = hht_pkg::DEFAULT_DATA,
   parameter int unsigned IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             rd,
   input  word_t            addr,
   input  word_t            base,
   input  logic             serve_ok,
   output logic [IDX_W-1:0] idx,
   input  word_t            word,
   input  logic             written,
   output word_t            data,
   output logic             valid,
   output logic             oob
);

   word_t offset;
   logic  in_win;
   logic  unused_offset;

   // addr >= base guarantees the subtraction is exact, so no wrap is possible.
   assign offset        = addr - base;
   assign in_win        = (addr >= base) && (offset < DEPTH);
   assign idx           = offset[IDX_W-1:0];
   assign unused_offset = ^offset;

   // Register the read result; idle cycles keep data and drop the flags.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         data  <= '0;
         valid <= 1'b0;
         oob   <= 1'b0;
      end else if (rd) begin
         if (serve_ok) begin
            data  <= (in_win && written) ? word : DEFAULT_DATA;
            valid <= 1'b1;
            oob   <= !in_win;
         end else begin
            data  <= DEFAULT_DATA;
            valid <= 1'b0;
            oob   <= 1'b0;
         end
      end else begin
         valid <= 1'b0;
         oob   <= 1'b0;
      end
   end

endmodule

// File: rtl/hht_mem_server.sv
// Two-region word store: filled during LOAD, read through two independent
// one-cycle ports during SERVE. Phase FSM and write decode live here.
module hht_mem_server
   import hht_pkg::*;
#(
   parameter int unsigned COL_DEPTH    = 256,
   parameter int unsigned V_DEPTH      = 16,
   parameter word_t       DEFAULT_DATA = hht_pkg::DEFAULT_DATA
) (
   input  logic  Clk,
   input  logic  Rst,
   input  logic  mem_init,
   input  logic  WR,
   input  logic  wr_sel,
   input  word_t wr_addr,
   input  word_t wr_data,
   input  word_t wdata_col_base,
   input  word_t v_values_base,
   input  logic  RD1,
   input  word_t addr1,
   input  logic  RD2,
   input  word_t addr2,
   output word_t dataIn1,
   output logic  valid1,
   output logic  oob1,
   output word_t dataIn2,
   output logic  valid2,
   output logic  oob2,
   output logic  init_done,
   output logic  wr_err
);

   localparam int unsigned COL_IDX_W = (COL_DEPTH > 1) ? $clog2(COL_DEPTH) : 1;
   localparam int unsigned V_IDX_W   = (V_DEPTH > 1) ? $clog2(V_DEPTH) : 1;

   state_t state, next_state;
   word_t  col_base, v_base, col_base_eff, v_base_eff;
   word_t  col_mem [COL_DEPTH];
   word_t  v_mem   [V_DEPTH];
   logic [COL_DEPTH-1:0] col_written;
   logic [V_DEPTH-1:0]   v_written;
   logic   serve_ok, base_load;
   word_t  wr_base, wr_off, wr_depth;
   logic   wr_ok, col_we, v_we;
   logic   unused_wr_off;
   logic [COL_IDX_W-1:0] col_idx;
   logic [V_IDX_W-1:0]   v_idx;
   word_t  col_word, v_word;

   // Phase register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= next_state;
   end

   // Phase transitions; a read arriving in IDLE starts serving directly.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (mem_init) next_state = LOAD;
                  else if (RD1 || RD2) next_state = SERVE;
         LOAD:    if (!mem_init) next_state = SERVE;
         SERVE:   if (mem_init) next_state = LOAD;
         default: next_state = IDLE;
      endcase
   end

   // Only LOAD and SERVE are ever entered outside reset, so any change of
   // phase is an entry that re-samples the bases.
   assign base_load = (next_state != state);
   assign init_done = (state == SERVE);
   assign serve_ok  = (state == SERVE) || ((state == IDLE) && !mem_init);

   // Capture both region bases on entry to LOAD or SERVE.
   always_ff @(posedge Clk) begin
      if (base_load) begin
         col_base <= wdata_col_base;
         v_base   <= v_values_base;
      end
   end

   // The base registers are not yet loaded in IDLE, so an IDLE->SERVE read
   // uses the live inputs that are being captured on that same edge.
   assign col_base_eff = (state == IDLE) ? wdata_col_base : col_base;
   assign v_base_eff   = (state == IDLE) ? v_values_base  : v_base;

   // Write decode: region select, offset and bounds check.
   assign wr_base       = wr_sel ? v_base : col_base;
   assign wr_depth      = wr_sel ? word_t'(V_DEPTH) : word_t'(COL_DEPTH);
   assign wr_off        = wr_addr - wr_base;
   assign wr_ok         = (state == LOAD) && (wr_addr >= wr_base) && (wr_off < wr_depth);
   assign col_we        = WR && wr_ok && !wr_sel;
   assign v_we          = WR && wr_ok && wr_sel;
   assign unused_wr_off = ^wr_off;

   // Storage arrays; contents are masked by the written bits after reset.
   always_ff @(posedge Clk) begin
      if (col_we) col_mem[wr_off[COL_IDX_W-1:0]] <= wr_data;
      if (v_we)   v_mem[wr_off[V_IDX_W-1:0]]     <= wr_data;
   end

   // Per-word written bits and the rejected-write pulse.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         col_written <= '0;
         v_written   <= '0;
         wr_err      <= 1'b0;
      end else begin
         if (col_we) col_written[wr_off[COL_IDX_W-1:0]] <= 1'b1;
         if (v_we)   v_written[wr_off[V_IDX_W-1:0]]     <= 1'b1;
         wr_err <= WR && !wr_ok;
      end
   end

   assign col_word = col_mem[col_idx];
   assign v_word   = v_mem[v_idx];

   hht_rd_port #(
      .DEPTH        (COL_DEPTH),
      .DEFAULT_DATA (DEFAULT_DATA),
      .IDX_W        (COL_IDX_W)
   ) u_rd_col (
      .Clk      (Clk),
      .Rst      (Rst),
      .rd       (RD1),
      .addr     (addr1),
      .base     (col_base_eff),
      .serve_ok (serve_ok),
      .idx      (col_idx),
      .word     (col_word),
      .written  (col_written[col_idx]),
      .data     (dataIn1),
      .valid    (valid1),
      .oob      (oob1)
   );

   hht_rd_port #(
      .DEPTH        (V_DEPTH),
      .DEFAULT_DATA (DEFAULT_DATA),
      .IDX_W        (V_IDX_W)
   ) u_rd_v (
      .Clk      (Clk),
      .Rst      (Rst),
      .rd       (RD2),
      .addr     (addr2),
      .base     (v_base_eff),
      .serve_ok (serve_ok),
      .idx      (v_idx),
      .word     (v_word),
      .written  (v_written[v_idx]),
      .data     (dataIn2),
      .valid    (valid2),
      .oob      (oob2)
   );

endmodule
